// File: rtl/alu_seq_if.sv
// Command and response handshake bundle between the control path (master)
// and the ALU op sequencer (slave).
interface alu_seq_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 4
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DATA_W-1:0] cmd_a;
    logic [DATA_W-1:0] cmd_b;
    logic [SEL_W-1:0]  cmd_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_carry;
    logic              rsp_err;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Queues ALU requests, drives the combinational ALU one op at a time and returns
// the result with error flags. Define ALU_SEQ_STATS_EN for op/error counters.
module alu_op_sequencer #(
    parameter int DATA_W     = 8,
    parameter int SEL_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_seq_if.slave          seq,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry,
    output logic              busy
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_errs
`endif
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 2 * DATA_W + SEL_W;
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [SEL_W-1:0] OP_ADD   = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_DIV   = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_LAST  = SEL_W'(5);

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [SEL_W-1:0]    alu_sel_q;
    logic                rsp_valid_q, rsp_carry_q, rsp_err_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                full, empty, push, pop, capture, rsp_hs;
    logic [ENT_W-1:0]    head;
    logic [DATA_W+1:0]   cap_word;

    // Packs {err, carry, data}; the ALU output is undefined for div-by-zero
    // and unsupported selectors, so those cases substitute fixed values.
    function automatic logic [DATA_W+1:0] capture_rsp(
        input logic [SEL_W-1:0]  sel,
        input logic [DATA_W-1:0] b,
        input logic [DATA_W-1:0] res,
        input logic              carry
    );
        logic [DATA_W+1:0] r;
        if (sel == OP_ADD)
            r = {1'b0, carry, res};
        else if (sel == OP_DIV && b == '0)
            r = {1'b1, 1'b0, {DATA_W{1'b1}}};
        else if (sel > OP_LAST)
            r = {1'b1, 1'b0, {DATA_W{1'b0}}};
        else
            r = {2'b00, res};
        return r;
    endfunction

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign push     = seq.cmd_valid && !full;
    assign head     = mem_q[rd_ptr_q];
    assign rsp_hs   = rsp_valid_q && seq.rsp_ready;
    assign cap_word = capture_rsp(alu_sel_q, alu_b_q, alu_result, alu_carry);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                capture = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (rsp_hs) begin
                    pop     = !empty;
                    state_d = empty ? IDLE : DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Entry storage carries no reset; occupancy is tracked by count/pointers.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {seq.cmd_a, seq.cmd_b, seq.cmd_sel};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                alu_a_q   <= head[ENT_W-1 -: DATA_W];
                alu_b_q   <= head[SEL_W +: DATA_W];
                alu_sel_q <= head[SEL_W-1:0];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= cap_word[DATA_W+1];
                rsp_carry_q <= cap_word[DATA_W];
                rsp_data_q  <= cap_word[DATA_W-1:0];
            end else if (rsp_hs) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops_q, stat_errs_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_ops_q  <= '0;
            stat_errs_q <= '0;
        end else if (rsp_hs) begin
            if (stat_ops_q != 16'hFFFF)
                stat_ops_q <= stat_ops_q + 16'd1;
            if (rsp_err_q && stat_errs_q != 16'hFFFF)
                stat_errs_q <= stat_errs_q + 16'd1;
        end
    end

    assign stat_ops  = stat_ops_q;
    assign stat_errs = stat_errs_q;
`endif

    assign seq.cmd_ready = !full;
    assign seq.rsp_valid = rsp_valid_q;
    assign seq.rsp_data  = rsp_data_q;
    assign seq.rsp_carry = rsp_carry_q;
    assign seq.rsp_err   = rsp_err_q;
    assign alu_a         = alu_a_q;
    assign alu_b         = alu_b_q;
    assign alu_sel       = alu_sel_q;
    assign busy          = !empty || (state_q != IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: vector table plus backpressure and
// mid-operation reset sequences, with a behavioural 8-bit ALU attached.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [3:0] alu_sel;
    logic       alu_carry, busy;
    logic [8:0] alu_s;
`ifdef ALU_SEQ_STATS_EN
    logic [15:0] stat_ops, stat_errs;
`endif

    int total  = 0;
    int passed = 0;

    alu_seq_if #(.DATA_W(8), .SEL_W(4)) bus ();

    alu_op_sequencer #(.DATA_W(8), .SEL_W(4), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seq        (bus.slave),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .alu_carry  (alu_carry),
        .busy       (busy)
`ifdef ALU_SEQ_STATS_EN
        ,
        .stat_ops   (stat_ops),
        .stat_errs  (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    // Reference ALU; undefined cases return junk so the sequencer must mask them.
    always_comb begin
        alu_s      = '0;
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_sel)
            4'd0: begin alu_s = {1'b0, alu_a} + {1'b0, alu_b}; alu_result = alu_s[7:0]; alu_carry = alu_s[8]; end
            4'd1: begin alu_s = {1'b0, alu_a} - {1'b0, alu_b}; alu_result = alu_s[7:0]; alu_carry = alu_s[8]; end
            4'd2: alu_result = alu_a * alu_b;
            4'd3: begin alu_result = (alu_b == 0) ? 8'hAA : alu_a / alu_b; alu_carry = (alu_b == 0); end
            4'd4: begin alu_result = {alu_a[6:0], 1'b0}; alu_carry = alu_a[7]; end
            4'd5: begin alu_result = {1'b0, alu_a[7:1]}; alu_carry = alu_a[0]; end
            default: begin alu_result = 8'h5A; alu_carry = 1'b1; end
        endcase
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] sel;
        logic [7:0] data;
        logic       carry;
        logic       err;
    } vec_t;

    vec_t vecs [10];
    logic [7:0] exp_bp [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
        int n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_sel   = sel;
        while (!bus.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("push_timeout", n, 0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 20) check("rsp_timeout", lat, 0);
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        push(v.a, v.b, v.sel);
        wait_rsp(lat);
        check($sformatf("latency[%0d]", idx), lat, 2);
        check($sformatf("data[%0d]", idx), bus.rsp_data, v.data);
        check($sformatf("carry[%0d]", idx), bus.rsp_carry, v.carry);
        check($sformatf("err[%0d]", idx), bus.rsp_err, v.err);
        @(negedge clk);
        check($sformatf("valid_clr[%0d]", idx), bus.rsp_valid, 0);
    endtask

    initial begin
        int got, n, seen;
        logic pend;

        vecs[0] = '{a: 8'd200, b: 8'd100, sel: 4'd0,  data: 8'h2C, carry: 1'b1, err: 1'b0};
        vecs[1] = '{a: 8'd7,   b: 8'd9,   sel: 4'd2,  data: 8'h3F, carry: 1'b0, err: 1'b0};
        vecs[2] = '{a: 8'h81,  b: 8'h00,  sel: 4'd4,  data: 8'h02, carry: 1'b0, err: 1'b0};
        vecs[3] = '{a: 8'h10,  b: 8'h00,  sel: 4'd3,  data: 8'hFF, carry: 1'b0, err: 1'b1};
        vecs[4] = '{a: 8'h33,  b: 8'h44,  sel: 4'd10, data: 8'h00, carry: 1'b0, err: 1'b1};
        vecs[5] = '{a: 8'h81,  b: 8'h00,  sel: 4'd5,  data: 8'h40, carry: 1'b0, err: 1'b0};
        vecs[6] = '{a: 8'd100, b: 8'd7,   sel: 4'd3,  data: 8'h0E, carry: 1'b0, err: 1'b0};
        vecs[7] = '{a: 8'h10,  b: 8'h20,  sel: 4'd1,  data: 8'hF0, carry: 1'b0, err: 1'b0};
        vecs[8] = '{a: 8'hFF,  b: 8'h01,  sel: 4'd0,  data: 8'h00, carry: 1'b1, err: 1'b0};
        vecs[9] = '{a: 8'd5,   b: 8'd5,   sel: 4'd15, data: 8'h00, carry: 1'b0, err: 1'b1};
        exp_bp = '{8'h02, 8'h08, 8'h00, 8'hFF, 8'h00, 8'h00};

        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_sel   = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_bits", {bus.rsp_data, bus.rsp_carry, bus.rsp_err}, 0);
        check("rst_alu_regs", {alu_a, alu_b, alu_sel}, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", bus.cmd_ready, 1);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
`ifdef ALU_SEQ_STATS_EN
        check("stat_ops", stat_ops, 5);
        check("stat_errs", stat_errs, 2);
`endif
        for (int i = 5; i < 10; i++) run_vec(vecs[i], i);

        // Backpressure: one op held in the FSM, four queued, sixth stalls.
        bus.rsp_ready = 1'b0;
        push(8'd5, 8'd3, 4'd1);
        push(8'd9, 8'd1, 4'd1);
        push(8'd4, 8'd4, 4'd1);
        push(8'd0, 8'd1, 4'd1);
        push(8'd2, 8'd2, 4'd1);
        check("bp_full_ready", bus.cmd_ready, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = 8'd7;
        bus.cmd_b     = 8'd7;
        bus.cmd_sel   = 4'd1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_stall_ready", bus.cmd_ready, 0);
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_data", bus.rsp_data, 8'h02);
        end
        bus.rsp_ready = 1'b1;
        got  = 0;
        n    = 0;
        pend = 1'b0;
        while (got < 6 && n < 100) begin
            if (pend) begin
                bus.cmd_valid = 1'b0;
                pend = 1'b0;
            end
            if (bus.cmd_valid && bus.cmd_ready) pend = 1'b1;
            if (bus.rsp_valid) begin
                check($sformatf("bp_data[%0d]", got), bus.rsp_data, exp_bp[got]);
                check($sformatf("bp_err[%0d]", got), bus.rsp_err, 0);
                got++;
            end
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        check("bp_rsp_count", got, 6);
        n = 0;
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_drained", busy, 0);

        // Reset while DRIVE is active with two commands still queued.
        bus.rsp_ready = 1'b0;
        push(8'd1, 8'd2, 4'd0);
        push(8'd3, 8'd4, 4'd0);
        push(8'd5, 8'd6, 4'd0);
        push(8'd7, 8'd8, 4'd0);
        check("mid_hold_valid", bus.rsp_valid, 1);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check("mid_drive_alu_a", alu_a, 8'd3);
        check("mid_drive_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp", {bus.rsp_valid, bus.rsp_data, bus.rsp_carry, bus.rsp_err}, 0);
        check("mid_rst_alu", {alu_a, alu_b, alu_sel}, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("mid_no_rsp", seen, 0);
        check("mid_idle_busy", busy, 0);
        run_vec('{a: 8'd1, b: 8'd1, sel: 4'd0, data: 8'h02, carry: 1'b0, err: 1'b0}, 99);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side initiator for the 8-bit combinational ALU. It accepts operation requests over a valid/ready interface and buffers them in a small FIFO. Each request drives the ALU operand/select inputs, the ALU result and carry are captured one cycle later, and the result is returned on a valid/ready response interface. The block sits between the control path and the ALU, and flags divide-by-zero and unsupported selectors in place of the ALU's undefined outputs.

Parameters:
DATA_W, 8, operand/result width; must match the ALU
SEL_W, 4, selector width
FIFO_DEPTH, 4, command FIFO entries; power of two, >= 2

Ports:
clk  in  1  single clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  request present
cmd_ready  out  1  FIFO can accept; equals !full
cmd_a  in  DATA_W  operand a
cmd_b  in  DATA_W  operand b
cmd_sel  in  SEL_W  op code: 0 add, 1 sub, 2 mul, 3 div, 4 shl1, 5 shr1
alu_a  out  DATA_W  registered operand to ALU
alu_b  out  DATA_W  registered operand to ALU
alu_sel  out  SEL_W  registered selector to ALU
alu_result  in  DATA_W  ALU result (combinational from alu_a/alu_b/alu_sel)
alu_carry  in  1  ALU carry
rsp_valid  out  1  response held
rsp_ready  in  1  consumer accepts
rsp_data  out  DATA_W  result
rsp_carry  out  1  carry; valid for add only
rsp_err  out  1  div-by-zero or unsupported selector
busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, rst_n=0): FIFO emptied, FSM=IDLE. alu_a, alu_b, alu_sel, rsp_data = 0; rsp_valid, rsp_carry, rsp_err = 0; busy=0. cmd_ready=1 once reset is released.
- Command push: on cmd_valid && cmd_ready. With a push and a pop in the same cycle, the count is unchanged. With cmd_ready=0, the command is ignored and the bench must hold it. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into alu_a/alu_b/alu_sel and go to DRIVE.
  - DRIVE: exactly one cycle for the ALU to settle. At the clock edge, capture the response and set rsp_valid=1, then go to HOLD.
  - HOLD: wait for rsp_valid && rsp_ready. On the handshake, clear rsp_valid. If the FIFO is non-empty, pop and load the ALU registers in the same edge and go to DRIVE (no idle bubble). Otherwise go to IDLE.
- Latency: a command accepted at edge E0 into an empty, idle block gives rsp_valid=1 after edge E2. Back-to-back throughput with rsp_ready held at 1 is one response per 2 cycles.
- Capture rules:
  - sel 0,1,2,4,5: rsp_data=alu_result, rsp_err=0.
  - rsp_carry=alu_carry when sel==0, else 0.
  - sel 3 with alu_b==0: rsp_data=8'hFF, rsp_err=1, rsp_carry=0.
  - sel 6..15: rsp_data=0, rsp_err=1, rsp_carry=0. The ALU output is ignored because it is undefined for these selectors.
- rsp_data, rsp_carry and rsp_err are stable while rsp_valid=1 and rsp_ready=0.
- alu_a, alu_b and alu_sel hold their last value between operations.
- Reset mid-operation: queued and in-flight commands are dropped and no response is issued.

Optional Feature:
ALU_SEQ_STATS_EN
- Defined: adds outputs stat_ops[15:0] and stat_errs[15:0].
  - stat_ops increments on each response handshake.
  - stat_errs increments on each handshake with rsp_err=1.
  - Both counters saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
1. Add with carry: cmd a=200, b=100, sel=0, rsp_ready=1 -> rsp_valid after E2; rsp_data=0x2C, rsp_carry=1, rsp_err=0.
2. Multiply: a=7, b=9, sel=2 -> rsp_data=0x3F, rsp_carry=0. Shift: a=0x81, sel=4 -> rsp_data=0x02, rsp_carry=0.
3. Divide-by-zero: a=0x10, b=0, sel=3 -> rsp_data=0xFF, rsp_err=1. Unsupported selector: sel=4'b1010 -> rsp_data=0x00, rsp_err=1.
4. Backpressure: rsp_ready=0; push 5 commands (sub 5-3, 9-1, 4-4, 0-1, 2-2).
   - First command pops into the FSM; 4 more fill the FIFO; cmd_ready=0.
   - 6th push stalls.
   - Release rsp_ready -> responses 0x02, 0x08, 0x00, 0xFF, 0x00 in order; data stable while stalled.
5. Reset mid-op: assert rst_n=0 during DRIVE with 2 commands queued.
   - All outputs return to 0 and busy=0.
   - After release, no response appears; a new add 1+1 returns 0x02.
6. With ALU_SEQ_STATS_EN: run tests 1-3 (5 responses, 2 errors) -> stat_ops=5, stat_errs=2.
